// File: rtl/input_event_pkg.sv
// -----------------------------------------------------------------------------
// input_event_pkg
//   Shared definitions for the input event conditioner:
//     - POL_LOW / POL_HIGH : polarity selectors for the POLARITY parameter
//     - clog2()            : ceiling log2 used to size counters
// -----------------------------------------------------------------------------
package input_event_pkg;

  // Polarity selectors. POLARITY is compared against these as a bit
  // string, so "LOW" means a low pin is the active state.
  localparam POL_LOW  = "LOW";
  localparam POL_HIGH = "HIGH";

  // Ceiling log2, never less than 1 so a counter always has at least
  // one bit even for degenerate parameter values.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/input_event_chan.sv
// -----------------------------------------------------------------------------
// input_event_chan
//   One input channel: synchroniser, debounce, edge classification and
//   pulse stretcher.
//
// Ports
//   fpga_clk_50       in   clock
//   hps_fpga_reset_n  in   asynchronous active-low reset
//   data_in           in   raw asynchronous pin
//   data_out          out  debounced level, 1 = active
//   pulse_out         out  PULSE_EXT-cycle pulse on every accepted change
//   rise              out  accepted inactive->active change this cycle (comb)
//   fall              out  accepted active->inactive change this cycle (comb)
// -----------------------------------------------------------------------------
module input_event_chan
  import input_event_pkg::*;
#(
  parameter     POLARITY      = "LOW",
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 50000,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int PULSE_EXT     = 2
) (
  input  logic fpga_clk_50,
  input  logic hps_fpga_reset_n,
  input  logic data_in,
  output logic data_out,
  output logic pulse_out,
  output logic rise,
  output logic fall
);

  localparam bit   ACTIVE_LOW = (POLARITY == POL_LOW);
  // Pin level that represents "inactive"; the synchroniser resets to it so
  // a pin held active through reset is seen as a fresh change afterwards.
  localparam logic IDLE_PIN   = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam int   PULSE_W    = clog2(PULSE_EXT + 1);

  logic [SYNC_STAGES-1:0]   sync_reg;
  logic [TIMEOUT_WIDTH-1:0] cnt_reg;
  logic [TIMEOUT_WIDTH-1:0] cnt_next;
  logic                     level_reg;
  logic                     level_next;
  logic [PULSE_W-1:0]       pulse_cnt_reg;
  logic [PULSE_W-1:0]       pulse_cnt_next;

  logic active;
  logic differ;
  logic at_limit;
  logic chg;

  // ---------------------------------------------------------------------------
  // Synchroniser: sample enters at bit 0, leaves at the top bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      sync_reg <= {SYNC_STAGES{IDLE_PIN}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], data_in};
    end
  end

  assign active = ACTIVE_LOW ? ~sync_reg[SYNC_STAGES-1] : sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: the counter measures how long the synchronised level has
  // disagreed with the accepted level. Any agreeing sample restarts it,
  // so only an unbroken run of TIMEOUT disagreeing samples is accepted.
  // ---------------------------------------------------------------------------
  assign differ   = active ^ level_reg;
  assign at_limit = (cnt_reg == TIMEOUT_WIDTH'(TIMEOUT - 1));
  assign chg      = differ & at_limit;

  // Classification uses the level before the toggle.
  assign rise = chg & ~level_reg;
  assign fall = chg &  level_reg;

  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    if (!differ) begin
      cnt_next = '0;
    end else if (at_limit) begin
      cnt_next   = '0;
      level_next = ~level_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stretcher: counts remaining pulse cycles. A change during a running
  // pulse reloads the full length, so back-to-back changes never leave a gap.
  // ---------------------------------------------------------------------------
  always_comb begin
    pulse_cnt_next = pulse_cnt_reg;
    if (chg) begin
      pulse_cnt_next = PULSE_W'(PULSE_EXT);
    end else if (pulse_cnt_reg != '0) begin
      pulse_cnt_next = pulse_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      cnt_reg       <= '0;
      level_reg     <= 1'b0;
      pulse_cnt_reg <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      level_reg     <= level_next;
      pulse_cnt_reg <= pulse_cnt_next;
    end
  end

  assign data_out  = level_reg;
  // Derived straight from the counter register, so it rises on the same
  // edge as data_out and stays high for exactly PULSE_EXT cycles.
  assign pulse_out = (pulse_cnt_reg != '0);

endmodule

// File: rtl/input_event_irq.sv
// -----------------------------------------------------------------------------
// input_event_irq
//   N-channel input conditioner for KEY/SW/GPIO lines with sticky per-channel
//   pending flags and one maskable level interrupt.
//
// Ports
//   fpga_clk_50       in   1      clock, 50 MHz
//   hps_fpga_reset_n  in   1      asynchronous active-low reset
//   data_in           in   WIDTH  raw asynchronous pins
//   rise_en           in   WIDTH  set pending[i] on inactive->active
//   fall_en           in   WIDTH  set pending[i] on active->inactive
//   irq_mask          in   WIDTH  1 = pending[i] contributes to irq
//   clr               in   WIDTH  one-cycle pulse, clears pending[i]
//   data_out          out  WIDTH  debounced level, 1 = active
//   pulse_out         out  WIDTH  stretched pulse on any accepted change
//   pending           out  WIDTH  sticky event flags
//   irq               out  1      registered OR of pending & irq_mask
// -----------------------------------------------------------------------------
module input_event_irq
  import input_event_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter     POLARITY      = "LOW",
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 50000,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int PULSE_EXT     = 2
) (
  input  logic             fpga_clk_50,
  input  logic             hps_fpga_reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] event_set;
  logic             irq_reg;
  logic             irq_next;

  // ---------------------------------------------------------------------------
  // Per-channel conditioning; channels share nothing.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      input_event_chan #(
        .POLARITY      (POLARITY),
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT       (TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
        .PULSE_EXT     (PULSE_EXT)
      ) u_chan (
        .fpga_clk_50      (fpga_clk_50),
        .hps_fpga_reset_n (hps_fpga_reset_n),
        .data_in          (data_in[gi]),
        .data_out         (data_out[gi]),
        .pulse_out        (pulse_out[gi]),
        .rise             (rise[gi]),
        .fall             (fall[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pending: enables are looked at only on the toggle edge, since rise/fall
  // are single-cycle. A set in the same cycle as clr wins so an event that
  // arrives while software acknowledges the previous one is not lost.
  // ---------------------------------------------------------------------------
  assign event_set = (rise & rise_en) | (fall & fall_en);

  always_comb begin
    pending_next = event_set | (pending_reg & ~clr);
    // The mask only gates the interrupt; pending itself is untouched by it.
    irq_next     = |(pending_reg & irq_mask);
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      pending_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      irq_reg     <= irq_next;
    end
  end

  assign pending = pending_reg;
  assign irq     = irq_reg;

endmodule

// File: tb/tb_input_event_irq.sv
// -----------------------------------------------------------------------------
// tb_input_event_irq
//   Directed bench for input_event_irq with WIDTH=4, TIMEOUT=8,
//   SYNC_STAGES=2, PULSE_EXT=3, POLARITY="LOW". Inputs change and outputs
//   are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_input_event_irq;

  logic       fpga_clk_50 = 1'b0;
  logic       hps_fpga_reset_n;
  logic [3:0] data_in;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] irq_mask;
  logic [3:0] clr;
  logic [3:0] data_out;
  logic [3:0] pulse_out;
  logic [3:0] pending;
  logic       irq;

  int checks = 0;
  int errors = 0;

  input_event_irq #(
    .WIDTH         (4),
    .POLARITY      ("LOW"),
    .SYNC_STAGES   (2),
    .TIMEOUT       (8),
    .TIMEOUT_WIDTH (4),
    .PULSE_EXT     (3)
  ) dut (
    .fpga_clk_50      (fpga_clk_50),
    .hps_fpga_reset_n (hps_fpga_reset_n),
    .data_in          (data_in),
    .rise_en          (rise_en),
    .fall_en          (fall_en),
    .irq_mask         (irq_mask),
    .clr              (clr),
    .data_out         (data_out),
    .pulse_out        (pulse_out),
    .pending          (pending),
    .irq              (irq)
  );

  always #10 fpga_clk_50 = ~fpga_clk_50;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge fpga_clk_50);
      #1;
    end
  endtask

  initial begin
    // ---- 1: reset ----
    hps_fpga_reset_n = 1'b0;
    data_in  = 4'hF;
    rise_en  = 4'h0;
    fall_en  = 4'h0;
    irq_mask = 4'h0;
    clr      = 4'h0;
    step(3);
    check_value("rst data_out", 32'(data_out), 32'h0);
    check_value("rst pulse_out", 32'(pulse_out), 32'h0);
    check_value("rst pending", 32'(pending), 32'h0);
    check_value("rst irq", 32'(irq), 32'h0);
    hps_fpga_reset_n = 1'b1;
    step(12);
    check_value("idle data_out", 32'(data_out), 32'h0);
    check_value("idle pulse_out", 32'(pulse_out), 32'h0);
    check_value("idle pending", 32'(pending), 32'h0);
    check_value("idle irq", 32'(irq), 32'h0);

    // ---- 2: ch0 press, accepted exactly 10 edges later ----
    rise_en  = 4'hF;
    irq_mask = 4'h1;
    data_in  = 4'b1110;
    step(9);
    check_value("t2 data_out@9", 32'(data_out), 32'h0);
    step(1);
    check_value("t2 data_out@10", 32'(data_out), 32'h1);
    check_value("t2 pulse@10", 32'(pulse_out), 32'h1);
    check_value("t2 pending@10", 32'(pending), 32'h1);
    check_value("t2 irq@10", 32'(irq), 32'h0);
    step(1);
    check_value("t2 irq@11", 32'(irq), 32'h1);
    check_value("t2 pulse@11", 32'(pulse_out), 32'h1);
    step(1);
    check_value("t2 pulse@12", 32'(pulse_out), 32'h1);
    step(1);
    check_value("t2 pulse@13", 32'(pulse_out), 32'h0);

    // ---- 3: ch1 bounce: low 7, high 1, then low held ----
    data_in = 4'b1100;
    step(7);
    data_in = 4'b1110;
    step(1);
    data_in = 4'b1100;
    step(2);
    check_value("t3 no early chg", 32'(data_out), 32'h1);
    check_value("t3 no early pulse", 32'(pulse_out), 32'h0);
    step(7);
    check_value("t3 data_out@9", 32'(data_out), 32'h1);
    check_value("t3 pending@9", 32'(pending), 32'h1);
    step(1);
    check_value("t3 data_out@10", 32'(data_out), 32'h3);
    check_value("t3 pending@10", 32'(pending), 32'h3);
    check_value("t3 pulse@10", 32'(pulse_out), 32'h2);
    step(3);

    // ---- 4: ch0 release with fall_en=0, then with fall_en=1 ----
    clr = 4'b0001;
    step(1);
    clr = 4'b0000;
    check_value("t4 clr pending", 32'(pending), 32'h2);
    step(1);
    check_value("t4 irq after clr", 32'(irq), 32'h0);
    data_in = 4'b1101;
    step(10);
    check_value("t4 release data_out", 32'(data_out), 32'h2);
    check_value("t4 release pulse", 32'(pulse_out), 32'h1);
    check_value("t4 release pending", 32'(pending), 32'h2);
    step(3);
    check_value("t4 pulse ended", 32'(pulse_out), 32'h0);
    rise_en = 4'b1110;
    fall_en = 4'b0001;
    data_in = 4'b1100;
    step(10);
    check_value("t4 press no-rise data", 32'(data_out), 32'h3);
    check_value("t4 press no-rise pend", 32'(pending), 32'h2);
    data_in = 4'b1101;
    step(10);
    check_value("t4 fall data_out", 32'(data_out), 32'h2);
    check_value("t4 fall pending", 32'(pending), 32'h3);
    step(1);
    check_value("t4 fall irq", 32'(irq), 32'h1);

    // ---- 5: ch2 clr collides with set; then clr; then mask ----
    clr      = 4'b0001;
    irq_mask = 4'b0100;
    data_in  = 4'b1001;
    step(1);
    clr = 4'b0000;
    check_value("t5 ch0 cleared", 32'(pending), 32'h2);
    step(8);
    clr = 4'b0100;
    step(1);
    clr = 4'b0000;
    check_value("t5 set wins data", 32'(data_out), 32'h6);
    check_value("t5 set wins pend", 32'(pending), 32'h6);
    clr = 4'b0100;
    step(1);
    clr = 4'b0000;
    check_value("t5 clr pending", 32'(pending), 32'h2);
    check_value("t5 irq lags", 32'(irq), 32'h1);
    step(1);
    check_value("t5 irq fell", 32'(irq), 32'h0);
    fall_en = 4'b0101;
    data_in = 4'b1101;
    step(10);
    check_value("t5 ch2 fall pend", 32'(pending), 32'h6);
    step(1);
    check_value("t5 irq on", 32'(irq), 32'h1);
    irq_mask = 4'b0000;
    step(1);
    check_value("t5 masked irq", 32'(irq), 32'h0);
    check_value("t5 masked pend", 32'(pending), 32'h6);

    // ---- 6: reset mid-pulse (ch0) and mid-count (ch3, cnt=5) ----
    rise_en = 4'hF;
    data_in = 4'b1100;
    step(3);
    data_in = 4'b0100;
    step(7);
    check_value("t6 pre-rst data", 32'(data_out), 32'h3);
    check_value("t6 pre-rst pulse", 32'(pulse_out), 32'h1);
    hps_fpga_reset_n = 1'b0;
    #1;
    check_value("t6 rst data", 32'(data_out), 32'h0);
    check_value("t6 rst pulse", 32'(pulse_out), 32'h0);
    check_value("t6 rst pending", 32'(pending), 32'h0);
    check_value("t6 rst irq", 32'(irq), 32'h0);
    step(2);
    irq_mask = 4'hF;
    hps_fpga_reset_n = 1'b1;
    step(9);
    check_value("t6 data@9", 32'(data_out), 32'h0);
    step(1);
    check_value("t6 data@10", 32'(data_out), 32'hB);
    check_value("t6 pend@10", 32'(pending), 32'hB);
    check_value("t6 pulse@10", 32'(pulse_out), 32'hB);
    step(1);
    check_value("t6 irq@11", 32'(irq), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
